// File: rtl/axi4_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// axi4_lite_slave_regfile
//
// AXI4-Lite slave that terminates the five AXI channels into a bank of
// NUM_REGS 32-bit registers. Writes honour byte strobes, reads return the
// register contents, and addresses beyond the bank complete with SLVERR.
//
// Ports
//   aclk, areset          clock and synchronous active-high reset
//   aw*                   write address channel (awprot is ignored)
//   w*                    write data channel with byte strobes
//   b*                    write response channel (OKAY / SLVERR)
//   ar*                   read address channel (arprot is ignored)
//   r*                    read data channel (OKAY / SLVERR)
//   regs_flat             live register contents, reg k at [32k+31:32k]
// ---------------------------------------------------------------------------
module axi4_lite_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic [2:0]               arprot,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [32*NUM_REGS-1:0]   regs_flat
);

    localparam int IDXW = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    // Register bank
    logic [31:0] regs_reg [NUM_REGS];

    // Write side state
    w_state_t               w_state_reg;
    logic                   aw_held_reg;
    logic                   w_held_reg;
    logic [ADDR_WIDTH-1:0]  awaddr_reg;
    logic [31:0]            wdata_reg;
    logic [3:0]             wstrb_reg;
    logic                   bvalid_reg;
    logic [1:0]             bresp_reg;

    // Read side state
    r_state_t               r_state_reg;
    logic                   rvalid_reg;
    logic [1:0]             rresp_reg;
    logic [31:0]            rdata_reg;

    // -----------------------------------------------------------------------
    // Handshake qualifiers. Readies depend only on registered state and
    // reset, never on the valids.
    // -----------------------------------------------------------------------
    assign awready = !areset && (w_state_reg == W_IDLE) && !aw_held_reg;
    assign wready  = !areset && (w_state_reg == W_IDLE) && !w_held_reg;
    assign arready = !areset && (r_state_reg == R_IDLE);

    logic aw_fire;
    logic w_fire;
    logic ar_fire;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid  && wready;
    assign ar_fire = arvalid && arready;

    // Effective write payload: the held copy if that half arrived earlier,
    // otherwise the live bus value being accepted this cycle.
    logic [ADDR_WIDTH-1:0] aw_addr_eff;
    logic [31:0]           w_data_eff;
    logic [3:0]            w_strb_eff;
    assign aw_addr_eff = aw_held_reg ? awaddr_reg : awaddr;
    assign w_data_eff  = w_held_reg  ? wdata_reg  : wdata;
    assign w_strb_eff  = w_held_reg  ? wstrb_reg  : wstrb;

    // Commit fires on the edge where both halves are present.
    logic commit;
    assign commit = (w_state_reg == W_IDLE)
                 && (aw_held_reg || aw_fire)
                 && (w_held_reg  || w_fire);

    logic [IDXW-1:0] w_idx;
    logic            w_oor;
    assign w_idx = aw_addr_eff[2+IDXW-1:2];
    assign w_oor = |aw_addr_eff[ADDR_WIDTH-1:2+IDXW];

    logic [IDXW-1:0] r_idx;
    logic            r_oor;
    assign r_idx = araddr[2+IDXW-1:2];
    assign r_oor = |araddr[ADDR_WIDTH-1:2+IDXW];

    // Byte-lane bits and protection fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, aw_addr_eff[1:0], araddr[1:0]};

    // -----------------------------------------------------------------------
    // Write FSM and register bank
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_reg <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_reg[k] <= '0;
            end
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_held_reg <= 1'b1;
                        awaddr_reg  <= awaddr;
                    end
                    if (w_fire) begin
                        w_held_reg <= 1'b1;
                        wdata_reg  <= wdata;
                        wstrb_reg  <= wstrb;
                    end
                    if (commit) begin
                        if (!w_oor) begin
                            for (int b = 0; b < 4; b++) begin
                                if (w_strb_eff[b]) begin
                                    regs_reg[w_idx][8*b +: 8] <= w_data_eff[8*b +: 8];
                                end
                            end
                        end
                        bresp_reg   <= w_oor ? RESP_SLVERR : RESP_OKAY;
                        bvalid_reg  <= 1'b1;
                        w_state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_reg  <= 1'b0;
                        aw_held_reg <= 1'b0;
                        w_held_reg  <= 1'b0;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Read FSM. Data is taken from the pre-edge bank, so a read accepted on
    // the same edge as a write commit returns the old contents.
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_reg <= R_IDLE;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_fire) begin
                        rdata_reg   <= r_oor ? 32'h0 : regs_reg[r_idx];
                        rresp_reg   <= r_oor ? RESP_SLVERR : RESP_OKAY;
                        rvalid_reg  <= 1'b1;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid_reg  <= 1'b0;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    assign bvalid = bvalid_reg;
    assign bresp  = bresp_reg;
    assign rvalid = rvalid_reg;
    assign rresp  = rresp_reg;
    assign rdata  = rdata_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[32*gi +: 32] = regs_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// Testbench for axi4_lite_slave_regfile (NUM_REGS = 8, ADDR_WIDTH = 32).
// Directed scenarios followed by randomized writes/reads, all checked
// against a simple array model of the register bank.
// ---------------------------------------------------------------------------
module tb_axi4_lite_slave_regfile;

    localparam int NR = 8;

    logic          aclk;
    logic          areset;
    logic [31:0]   awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [31:0]   araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [32*NR-1:0] regs_flat;

    axi4_lite_slave_regfile #(
        .ADDR_WIDTH(32),
        .NUM_REGS  (NR)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .awaddr   (awaddr),
        .awprot   (awprot),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arprot   (arprot),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .regs_flat(regs_flat)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int vectors;
    int miscompares;
    logic [31:0] model [NR];

    // ---------------- reference model helpers ----------------
    function automatic bit in_range(input logic [31:0] addr);
        return addr < 32'(NR * 4);
    endfunction

    function automatic int reg_index(input logic [31:0] addr);
        return int'((addr / 4) % NR);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return in_range(addr) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        int i;
        if (in_range(addr)) begin
            i = reg_index(addr);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[i][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return in_range(addr) ? model[reg_index(addr)] : 32'h0;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NR; k++)
            check($sformatf("%s[%0d]", tag, k), regs_flat[32*k +: 32], model[k]);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Write with AW presented at cycle da, W at cycle dw, bready held low bd cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int da, input int dw,
                            input int bd);
        bit aw_done, w_done, aw_hs, w_hs;
        logic [1:0] er;
        aw_done = 0;
        w_done  = 0;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        awprot = 3'($urandom);
        for (int t = 0; t < 20 && !(aw_done && w_done); t++) begin
            awvalid = !aw_done && (t >= da);
            wvalid  = !w_done  && (t >= dw);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            if (w_done && !aw_done) begin
                check("wready_low_after_w", 32'(wready), 32'h0);
                check_regs("no_commit_before_aw");
            end
        end
        awvalid = 0;
        wvalid  = 0;
        check("aw_w_handshakes", 32'({aw_done, w_done}), 32'h3);
        er = exp_resp(addr);
        check("bvalid_latency", 32'(bvalid), 32'h1);
        check("bresp", 32'(bresp), 32'(er));
        model_write(addr, data, strb);
        for (int s = 0; s < bd; s++) begin
            tick();
            check("bvalid_stall", 32'(bvalid), 32'h1);
            check("bresp_stall", 32'(bresp), 32'(er));
            check("awready_stall", 32'({awready, wready}), 32'h0);
        end
        bready = 1;
        tick();
        bready = 0;
        check("bvalid_clear", 32'(bvalid), 32'h0);
        check("aw_w_ready_back", 32'({awready, wready}), 32'h3);
        check_regs("regs_after_write");
        $display("write addr=0x%08h data=0x%08h strb=%b da=%0d dw=%0d -> bresp=%b",
                 addr, data, strb, da, dw, bresp);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rd);
        bit hs, hs_now;
        logic [31:0] ed;
        hs = 0;
        araddr  = addr;
        arprot  = 3'($urandom);
        arvalid = 1;
        for (int t = 0; t < 20 && !hs; t++) begin
            hs_now = arready;
            tick();
            if (hs_now) hs = 1;
        end
        arvalid = 0;
        ed = model_read(addr);
        check("ar_handshake", 32'(hs), 32'h1);
        check("rvalid_latency", 32'(rvalid), 32'h1);
        check("rdata", rdata, ed);
        check("rresp", 32'(rresp), 32'(exp_resp(addr)));
        for (int s = 0; s < rd; s++) begin
            tick();
            check("rvalid_stall", 32'(rvalid), 32'h1);
            check("rdata_stall", rdata, ed);
            check("arready_stall", 32'(arready), 32'h0);
        end
        rready = 1;
        tick();
        rready = 0;
        check("rvalid_clear", 32'(rvalid), 32'h0);
        check("arready_back", 32'(arready), 32'h1);
        $display("read  addr=0x%08h -> rdata=0x%08h rresp=%b", addr, rdata, rresp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] old_val;
        logic [31:0] a;

        vectors = 0;
        miscompares = 0;
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;

        // Reset state
        areset = 1;
        tick();
        tick();
        check("rst_readies", 32'({awready, wready, arready}), 32'h0);
        check("rst_valids", 32'({bvalid, rvalid}), 32'h0);
        check("rst_resps", 32'({bresp, rresp}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check_regs("rst_regs");
        areset = 0;
        tick();
        check("post_rst_readies", 32'({awready, wready, arready}), 32'h7);

        // 1: AW and W together, partial strobe
        do_write(32'h10, 32'hF0B4A596, 4'b1011, 0, 0, 0);
        check("t1_reg4", regs_flat[32*4 +: 32], 32'hF000A596);

        // 2: read it back
        do_read(32'h10, 0);

        // 3: W first, AW three cycles later
        do_write(32'h04, 32'h12345678, 4'hF, 3, 0, 0);
        check("t3_reg1", regs_flat[32*1 +: 32], 32'h12345678);

        // 4: out of range write and read
        do_write(32'h20, 32'hCAFEBABE, 4'hF, 0, 0, 0);
        do_read(32'h20, 0);
        check("t4_rresp", 32'(rresp), 32'h2);

        // 5: concurrent write+read to the same register, both stalled 4 cycles
        do_write(32'h08, 32'h11112222, 4'hF, 0, 0, 0);
        old_val = model_read(32'h08);
        awaddr = 32'h08; wdata = 32'hAAAA5555; wstrb = 4'hF; araddr = 32'h08;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        model_write(32'h08, 32'hAAAA5555, 4'hF);
        for (int s = 0; s < 4; s++) begin
            check("t5_valids", 32'({bvalid, rvalid}), 32'h3);
            check("t5_bresp", 32'(bresp), 32'h0);
            check("t5_rdata_old", rdata, old_val);
            check("t5_readies", 32'({awready, wready, arready}), 32'h0);
            tick();
        end
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        check("t5_valids_clear", 32'({bvalid, rvalid}), 32'h0);
        check("t5_readies_back", 32'({awready, wready, arready}), 32'h7);
        check_regs("t5_regs");
        $display("stall  write+read 0x08 -> old rdata=0x%08h", old_val);

        // 6: reset with a half-transaction pending
        awaddr = 32'h0C; awvalid = 1;
        tick();
        awvalid = 0;
        check("t6_aw_held", 32'(awready), 32'h0);
        areset = 1;
        tick();
        check("t6_rst_bvalid", 32'(bvalid), 32'h0);
        check("t6_rst_awready", 32'(awready), 32'h0);
        areset = 0;
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
        tick();
        check("t6_readies", 32'({awready, wready}), 32'h3);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        check("t6_no_stale_commit", 32'(bvalid), 32'h0);
        check_regs("t6_regs_clear");
        awaddr = 32'h18; awvalid = 1;
        tick();
        awvalid = 0;
        check("t6_bvalid", 32'(bvalid), 32'h1);
        check("t6_bresp", 32'(bresp), 32'h0);
        model_write(32'h18, 32'hDEADBEEF, 4'hF);
        bready = 1;
        tick();
        bready = 0;
        check_regs("t6_regs");
        $display("reset  mid-write, then write 0x18 -> reg6=0x%08h", regs_flat[32*6 +: 32]);
        do_write(32'h00, 32'h0BADF00D, 4'hF, 1, 0, 1);

        // Zero strobe: OKAY and no change
        do_write(32'h14, 32'hFFFFFFFF, 4'h0, 0, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
            do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2));
            a = 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
            do_read(a, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
